// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: owner encoding, hold default and round-robin helper shared by the arbiter and its users
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  localparam int DEF_MAX_HOLD = 8;

  function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
    return (r0 && r1) ? ~last : r1;
  endfunction
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter with bounded lock in front of a single-port synchronous memory
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_HOLD   = DEF_MAX_HOLD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  lock0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  lock1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  input  logic [DATA_WIDTH-1:0] mem_in,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  owner_t owner, owner_nx;
  logic last, win, any, forced, wlock;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic [1:0] rd_pend;

  always_comb begin
    any = req0 | req1;
    forced = (hold_cnt == HOLD_MAX) &&
             (owner == OWN_P0 ? req1 : owner == OWN_P1 ? req0 : 1'b0);
    // a forced rotation always hands the memory to the non-owner
    win = (owner == OWN_P0 && req0 && !forced) ? 1'b0 :
          (owner == OWN_P1 && req1 && !forced) ? 1'b1 :
          forced ? (owner == OWN_P0) : rr_pick(req0, req1, last);
    gnt0 = any && !win;
    gnt1 = any && win;
    wlock = win ? lock1 : lock0;
    owner_nx = (any && wlock) ? (win ? OWN_P1 : OWN_P0) : OWN_NONE;
    hold_nx = (owner_nx == owner && owner != OWN_NONE) ?
              (hold_cnt == HOLD_MAX ? hold_cnt : hold_cnt + 1'b1) : '0;
    mem_we = any && (win ? we1 : we0);
    mem_addr = any ? (win ? addr1 : addr0) : '0;
    mem_data = any ? (win ? wdata1 : wdata0) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= OWN_NONE;
      last <= 1'b1;
      hold_cnt <= '0;
      rd_pend <= '0;
    end else begin
      owner <= owner_nx;
      hold_cnt <= hold_nx;
      if (any) last <= win;
      rd_pend <= {gnt1 && !we1, gnt0 && !we0};
    end
  end

  assign rvalid0 = rd_pend[0];
  assign rvalid1 = rd_pend[1];
  assign rdata0 = rvalid0 ? mem_in : '0;
  assign rdata1 = rvalid1 ? mem_in : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed plus random stimulus against a rule-level reference model with a behavioural memory
module tb_mem_arbiter;
  localparam int MAX_HOLD = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req [2];
  logic lock [2];
  logic we [2];
  logic [5:0] addr [2];
  logic [15:0] wdata [2];
  logic gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [15:0] rdata0, rdata1, mem_data;
  logic [15:0] mem_in = '0;
  logic [5:0] mem_addr;
  logic [15:0] mem [64] = '{default: 16'h0};

  logic [15:0] ref_mem [64] = '{default: 16'h0};
  int m_owner, m_last, m_hold, last_w;
  bit exp_rv [2];
  logic [15:0] exp_rd [2];
  bit obs_g0, obs_g1;
  int n_tests = 0, n_fail = 0;

  mem_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req[0]), .lock0(lock[0]), .we0(we[0]), .addr0(addr[0]), .wdata0(wdata[0]),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req[1]), .lock1(lock[1]), .we1(we[1]), .addr1(addr[1]), .wdata1(wdata[1]),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_in(mem_in), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
    mem_in <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last = 1;
    m_hold = 0;
    exp_rv[0] = 0;
    exp_rv[1] = 0;
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      req[k] = 0; lock[k] = 0; we[k] = 0; addr[k] = '0; wdata[k] = '0;
    end
  endtask

  task automatic step();
    int w, nown;
    bit forced;
    @(negedge clk);
    forced = m_owner >= 0 && m_hold == MAX_HOLD && req[1 - m_owner];
    if (m_owner >= 0 && req[m_owner] && !forced) w = m_owner;
    else if (req[0] && req[1]) w = 1 - m_last;
    else if (req[0]) w = 0;
    else if (req[1]) w = 1;
    else w = -1;
    obs_g0 = gnt0;
    obs_g1 = gnt1;
    check("gnt0", gnt0, w == 0);
    check("gnt1", gnt1, w == 1);
    check("mem_we", mem_we, w >= 0 ? we[w] : 1'b0);
    check("mem_addr", mem_addr, w >= 0 ? addr[w] : 6'd0);
    check("mem_data", mem_data, (w >= 0) ? wdata[w] : 16'd0);
    check("rvalid0", rvalid0, exp_rv[0]);
    check("rvalid1", rvalid1, exp_rv[1]);
    check("rdata0", rdata0, exp_rv[0] ? exp_rd[0] : 16'd0);
    check("rdata1", rdata1, exp_rv[1] ? exp_rd[1] : 16'd0);
    last_w = w;
    @(posedge clk);
    nown = (w >= 0 && lock[w]) ? w : -1;
    m_hold = (nown >= 0 && nown == m_owner) ? (m_hold < MAX_HOLD ? m_hold + 1 : MAX_HOLD) : 0;
    m_owner = nown;
    if (w >= 0) m_last = w;
    for (int k = 0; k < 2; k++) begin
      exp_rv[k] = (w == k) && !we[k];
      if (exp_rv[k]) exp_rd[k] = ref_mem[addr[k]];
    end
    if (w >= 0 && we[w]) ref_mem[addr[w]] = wdata[w];
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
  endtask

  initial begin
    int run0;
    idle_inputs();
    model_reset();
    last_w = -1;
    #2;
    do_reset();
    check("reset_rvalid0", rvalid0, 1'b0);
    check("reset_gnt", {gnt1, gnt0}, 2'b00);

    // both ports read; port 0 wins the first tie, then port 1
    req[0] = 1; addr[0] = 6'd5; req[1] = 1; addr[1] = 6'd9;
    step();
    req[0] = 0;
    step();
    req[1] = 0;
    step();

    // single write from port 1
    req[1] = 1; we[1] = 1; addr[1] = 6'd3; wdata[1] = 16'hBEEF;
    step();
    idle_inputs();
    step();

    // locked port 0 keeps the memory 1 + MAX_HOLD cycles
    do_reset();
    req[0] = 1; lock[0] = 1; addr[0] = 6'd3; req[1] = 1; addr[1] = 6'd3;
    run0 = 0;
    for (int i = 0; i < MAX_HOLD + 2; i++) begin
      step();
      if (obs_g0 && i == run0) run0++;
    end
    check("hold_run", run0, MAX_HOLD + 1);
    check("hold_rotate", obs_g1, 1'b1);
    idle_inputs();
    step();

    // owner drops req mid-lock; port 1 takes over in the same cycle
    req[0] = 1; lock[0] = 1; req[1] = 1; lock[1] = 1; we[1] = 1; addr[1] = 6'd7; wdata[1] = 16'h1234;
    step();
    step();
    req[0] = 0;
    step();
    step();
    idle_inputs();
    step();

    // reset between a read grant and its data return
    req[0] = 1; addr[0] = 6'd3;
    @(negedge clk);
    check("t5_gnt0", gnt0, 1'b1);
    #2;
    rst_n = 0;
    req[0] = 0;
    #1;
    check("t5_rv_async", rvalid0, 1'b0);
    @(posedge clk);
    #1;
    check("t5_rv", rvalid0, 1'b0);
    check("t5_we", mem_we, 1'b0);
    rst_n = 1;
    model_reset();
    req[0] = 1; req[1] = 1; addr[1] = 6'd7;
    step();
    check("t5_first", obs_g0, 1'b1);
    idle_inputs();

    // quiet bus
    for (int i = 0; i < 5; i++) step();

    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (last_w == k || !req[k]) begin
          req[k] = $urandom_range(0, 3) != 0;
          we[k] = $urandom_range(0, 2) == 0;
          addr[k] = 6'($urandom_range(0, 7));
          wdata[k] = 16'($urandom);
        end
        lock[k] = (k == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) != 0);
      end
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        last_w = -1;
      end else begin
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single-port data/instruction memory between two requesters: port 0 (cpu) and port 1 (aux: program loader / debug / display reader).
- Per-cycle arbitration with round-robin fairness.
- Optional lock lets an owner hold the memory across multi-cycle sequences. A hold limit bounds lock duration so neither port starves.
- Sits between the requesters and the memory's address/data/we pins. Memory read is synchronous: data is valid on mem_in one cycle after the address.

Parameters:
ADDR_WIDTH, 6, memory address width
DATA_WIDTH, 16, memory word width
MAX_HOLD, 8, max consecutive locked cycles before forced rotation when the other port is requesting (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req0  input  1  port 0 access request
lock0  input  1  port 0 wants to keep ownership after this access
we0  input  1  port 0 write enable
addr0  input  ADDR_WIDTH  port 0 address
wdata0  input  DATA_WIDTH  port 0 write data
gnt0  output  1  port 0 access performed this cycle
rvalid0  output  1  port 0 read data valid on rdata0
rdata0  output  DATA_WIDTH  port 0 read data
req1, lock1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1
mem_in  input  DATA_WIDTH  memory read data (1-cycle latency)
mem_we  output  1  memory write enable
mem_addr  output  ADDR_WIDTH  memory address
mem_data  output  DATA_WIDTH  memory write data

Behaviour:
Clock/reset:
- One clock (clk); reset asynchronous, active-low (rst_n).
- Reset: owner=NONE, last=1 (port 0 wins first tie), hold_cnt=0, rd_pend=none, rvalid0=rvalid1=0.
- gnt*/mem_* are combinational; with no requests they are 0.

State registers:
- owner in {NONE, P0, P1}
- last: last granted port
- hold_cnt: counts up to MAX_HOLD
- rd_pend: 2 bits, one per port

Winner selection each cycle (combinational):
- owner=Pk and reqk=1 and not forced -> winner k.
- Else only one port requests -> that port.
- Else both request -> port != last (round-robin).
- Else none.
- forced = (hold_cnt == MAX_HOLD) and the other port's req=1.

Grant and memory drive:
- gntk = (winner==k). At most one gnt per cycle.
- Memory pins are driven from the winner's we/addr/wdata. No winner -> mem_we=0, mem_addr=0, mem_data=0.
- Requester holds req/addr/we/wdata stable until it sees gnt. Access completes in the gnt cycle (0-cycle arbitration latency).

Read return:
- A granted read (we=0) sets rd_pend[k] for the next cycle.
- rvalidk = registered rd_pend[k]; rdatak = mem_in while rvalidk=1, else 0.
- Writes produce no rvalid.
- Back-to-back reads by the same port give rvalid high on consecutive cycles.

Ownership update on each clock edge:
- Winner k with lockk=1 -> owner<=Pk.
- Otherwise -> owner<=NONE.
- On any grant, last<=winner.

hold_cnt:
- Increments while owner stays the same port and that port is granted again. Saturates at MAX_HOLD.
- Resets to 0 when owner changes or becomes NONE.
- Forced rotation: winner = the other port, owner<=that port if its lock=1, hold_cnt<=0.

Boundary conditions:
- Owner drops req while holding lock -> ownership released that cycle; normal arbitration applies.
- lock with req=0 is ignored.
- Reset mid-access clears rd_pend: no rvalid after reset.

Decomposition:
- Shared package: owner encoding (OWN_NONE=0, OWN_P0=1, OWN_P1=2) and the MAX_HOLD default, so cpu and top-level instantiate consistently.
- No sub-module is needed. A small rr_pick function (2-way round-robin select) may live in the package.

Test Plan:
1. After reset, req0=req1=1 reading addr 5/9 -> cycle 0 gnt0, mem_addr=5; cycle 1 gnt1, rvalid0 with mem_in; cycle 2 rvalid1. Round-robin alternates.
2. Only req1 write addr 3 data 16'hBEEF -> gnt1 same cycle, mem_we=1, mem_addr=3, mem_data=BEEF. No rvalid.
3. Port 0 lock0=1 with continuous req0, req1 asserted, MAX_HOLD=8 -> gnt0 for exactly 9 consecutive cycles, then gnt1. Owner rotates; hold_cnt=0.
4. Port 0 locked, drops req0 mid-sequence while req1=1 -> gnt1 in that same cycle; owner becomes P1 only if lock1=1.
5. Read granted, rst_n pulled low before next edge -> rvalid0 stays 0, mem_we=0, and first grant after reset goes to port 0.
6. No requests for 5 cycles -> gnt0=gnt1=0, mem_we=0, mem_addr=0, rvalid*=0 throughout.
